// File: rtl/sync_fifo_rv_if.sv
// sync_fifo_rv_if: enqueue/dequeue ready-valid bundle for sync_fifo_rv
interface sync_fifo_rv_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  enq_valid;
  logic                  enq_ready;
  logic [DATA_WIDTH-1:0] enq_data;
  logic                  deq_valid;
  logic                  deq_ready;
  logic [DATA_WIDTH-1:0] deq_data;
  modport master (
    output enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data
  );
  modport slave (
    input  enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data
  );
endinterface

// File: rtl/sync_fifo_rv.sv
// sync_fifo_rv: parametrised-depth ready/valid FIFO with first-word-fall-through output,
// occupancy/threshold flags and synchronous flush
module sync_fifo_rv #(
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  sync_fifo_rv_if.slave bus,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          almost_empty
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  enq;
  logic                  deq;
  assign bus.enq_ready = count != CW'(DEPTH);
  assign bus.deq_valid = count != '0;
  assign bus.deq_data  = bus.deq_valid ? mem[rd_ptr] : '0;
  assign almost_full   = count >= CW'(AFULL_THRESH);
  assign almost_empty  = count <= CW'(AEMPTY_THRESH);
  assign enq = bus.enq_valid && bus.enq_ready;
  assign deq = bus.deq_valid && bus.deq_ready;
  // a write landing during flush/reset is harmless: the pointers restart and never expose it
  always_ff @(posedge clk)
    if (enq) mem[wr_ptr] <= bus.enq_data;
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      if (enq && !deq) count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end
endmodule
